// File: rtl/tmr_addsub_result_stage.sv
// TMR vote of three {COUT,SUM} words into a 2-entry valid/ready queue; accept->OUT_VALID after 1 edge,
// IN_READY registered from queue state (low only when full). Optional sticky alarm: FT_STICKY_ALARM_EN.
module tmr_addsub_result_stage #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] IN_SUM_0,
    input  logic [WIDTH-1:0] IN_SUM_1,
    input  logic [WIDTH-1:0] IN_SUM_2,
    input  logic             IN_COUT_0,
    input  logic             IN_COUT_1,
    input  logic             IN_COUT_2,
    input  logic             IN_CLR_CNT,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT_SUM,
    output logic             OUT_COUT,
    output logic             OUT_FAULT,
    output logic             OUT_UNCORR,
    output logic [CNT_W-1:0] OUT_FAULT_CNT
`ifdef FT_STICKY_ALARM_EN
    ,
    output logic             OUT_ALARM
`endif
);

    typedef struct packed {
        logic             uncorr;
        logic             fault;
        logic [WIDTH:0]   word;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next_state;
    logic             r_in_ready;
    entry_t           r_head;
    entry_t           r_tail;
    logic [CNT_W-1:0] r_fault_cnt;

    logic [WIDTH:0]   w_copy_0;
    logic [WIDTH:0]   w_copy_1;
    logic [WIDTH:0]   w_copy_2;
    logic [WIDTH:0]   w_voted;
    logic             w_dis_0;
    logic             w_dis_1;
    logic             w_dis_2;
    logic             w_fault;
    logic             w_uncorr;
    entry_t           w_entry;
    logic             w_out_valid;
    logic             w_accept;
    logic             w_pop;

    // Bitwise majority; a copy disagrees if any of its bits lost the vote.
    assign w_copy_0 = {IN_COUT_0, IN_SUM_0};
    assign w_copy_1 = {IN_COUT_1, IN_SUM_1};
    assign w_copy_2 = {IN_COUT_2, IN_SUM_2};
    assign w_voted  = (w_copy_0 & w_copy_1) | (w_copy_0 & w_copy_2) | (w_copy_1 & w_copy_2);
    assign w_dis_0  = (w_copy_0 != w_voted);
    assign w_dis_1  = (w_copy_1 != w_voted);
    assign w_dis_2  = (w_copy_2 != w_voted);
    assign w_fault  = w_dis_0 | w_dis_1 | w_dis_2;
    assign w_uncorr = (w_dis_0 & w_dis_1) | (w_dis_0 & w_dis_2) | (w_dis_1 & w_dis_2);

    always_comb begin
        w_entry        = '0;
        w_entry.word   = w_voted;
        w_entry.fault  = w_fault;
        w_entry.uncorr = w_uncorr;
    end

    assign w_out_valid = (r_state != S_EMPTY);
    assign w_accept    = IN_VALID & r_in_ready;
    assign w_pop       = w_out_valid & OUT_READY;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state != S_FULL);
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_EMPTY: begin
                if (w_accept) w_next_state = S_ONE;
            end
            S_ONE: begin
                if (w_accept && !w_pop)      w_next_state = S_FULL;
                else if (w_pop && !w_accept) w_next_state = S_EMPTY;
            end
            S_FULL: begin
                if (w_pop) w_next_state = S_ONE;
            end
            default: w_next_state = S_EMPTY;
        endcase
    end

    always_comb begin
        IN_READY   = r_in_ready;
        OUT_VALID  = w_out_valid;
        OUT_SUM    = '0;
        OUT_COUT   = 1'b0;
        OUT_FAULT  = 1'b0;
        OUT_UNCORR = 1'b0;
        if (w_out_valid) begin
            OUT_SUM    = r_head.word[WIDTH-1:0];
            OUT_COUT   = r_head.word[WIDTH];
            OUT_FAULT  = r_head.fault;
            OUT_UNCORR = r_head.uncorr;
        end
    end

    // Head slot always feeds the outputs; the tail slot only fills when the head is held.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) r_head <= w_entry;
                end
                S_ONE: begin
                    if (w_accept && w_pop) r_head <= w_entry;
                    else if (w_accept)     r_tail <= w_entry;
                end
                S_FULL: begin
                    if (w_pop) r_head <= r_tail;
                end
                default: begin
                    r_head <= '0;
                    r_tail <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_fault_cnt <= '0;
        end else if (IN_CLR_CNT) begin
            r_fault_cnt <= '0;
        end else if (w_accept && w_fault && (r_fault_cnt != CNT_MAX)) begin
            r_fault_cnt <= r_fault_cnt + CNT_ONE;
        end
    end

    assign OUT_FAULT_CNT = r_fault_cnt;

`ifdef FT_STICKY_ALARM_EN
    logic r_alarm;

    // A new uncorrectable word outranks a clear arriving on the same edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_alarm <= 1'b0;
        end else if (w_accept && w_uncorr) begin
            r_alarm <= 1'b1;
        end else if (IN_CLR_CNT) begin
            r_alarm <= 1'b0;
        end
    end

    assign OUT_ALARM = r_alarm;
`endif

endmodule

// File: tb/tb_tmr_addsub_result_stage.sv
// Randomized + directed bench for tmr_addsub_result_stage against a queue-based reference model.
module tb_tmr_addsub_result_stage;
    localparam int W = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic in_valid = 1'b0, out_ready = 1'b0, clr = 1'b0;
    logic [W-1:0] s0 = '0, s1 = '0, s2 = '0;
    logic c0 = 1'b0, c1 = 1'b0, c2 = 1'b0;

    logic in_ready, out_valid, out_cout, out_fault, out_uncorr;
    logic [W-1:0] out_sum;
    logic [7:0] cnt8;
    logic in_ready_b, out_valid_b, out_cout_b, out_fault_b, out_uncorr_b;
    logic [W-1:0] out_sum_b;
    logic [1:0] cnt2;
`ifdef FT_STICKY_ALARM_EN
    logic alarm, alarm_b;
`endif

    tmr_addsub_result_stage #(.WIDTH(W), .CNT_W(8)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(in_valid), .IN_READY(in_ready),
        .IN_SUM_0(s0), .IN_SUM_1(s1), .IN_SUM_2(s2),
        .IN_COUT_0(c0), .IN_COUT_1(c1), .IN_COUT_2(c2), .IN_CLR_CNT(clr),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_SUM(out_sum), .OUT_COUT(out_cout),
        .OUT_FAULT(out_fault), .OUT_UNCORR(out_uncorr), .OUT_FAULT_CNT(cnt8)
`ifdef FT_STICKY_ALARM_EN
        , .OUT_ALARM(alarm)
`endif
    );

    tmr_addsub_result_stage #(.WIDTH(W), .CNT_W(2)) dut_b (
        .CLK(CLK), .RST(RST), .IN_VALID(in_valid), .IN_READY(in_ready_b),
        .IN_SUM_0(s0), .IN_SUM_1(s1), .IN_SUM_2(s2),
        .IN_COUT_0(c0), .IN_COUT_1(c1), .IN_COUT_2(c2), .IN_CLR_CNT(clr),
        .OUT_VALID(out_valid_b), .OUT_READY(out_ready), .OUT_SUM(out_sum_b), .OUT_COUT(out_cout_b),
        .OUT_FAULT(out_fault_b), .OUT_UNCORR(out_uncorr_b), .OUT_FAULT_CNT(cnt2)
`ifdef FT_STICKY_ALARM_EN
        , .OUT_ALARM(alarm_b)
`endif
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of voted entries plus counters.
    typedef struct {
        logic [4:0] word;
        bit         f;
        bit         u;
    } ent_t;

    ent_t mq[$];
    int   mcnt8 = 0;
    int   mcnt2 = 0;
    bit   malarm = 1'b0;

    function automatic void vote(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                                 output logic [4:0] v, output int d);
        for (int k = 0; k < 5; k++)
            v[k] = ((int'(a[k]) + int'(b[k]) + int'(c[k])) >= 2);
        d = int'(a != v) + int'(b != v) + int'(c != v);
    endfunction

    always @(posedge CLK or posedge RST) begin
        bit         acc, pp;
        ent_t       e;
        logic [4:0] v;
        int         d;
        if (RST) begin
            mq.delete();
            mcnt8  = 0;
            mcnt2  = 0;
            malarm = 1'b0;
        end else begin
            acc = in_valid && (mq.size() < 2);
            pp  = (mq.size() > 0) && out_ready;
            vote({c0, s0}, {c1, s1}, {c2, s2}, v, d);
            e.word = v;
            e.f    = (d >= 1);
            e.u    = (d >= 2);
            if (pp) void'(mq.pop_front());
            if (acc) mq.push_back(e);
            if (clr) begin
                mcnt8 = 0;
                mcnt2 = 0;
            end else if (acc && e.f) begin
                if (mcnt8 < 255) mcnt8++;
                if (mcnt2 < 3) mcnt2++;
            end
            if (acc && e.u) malarm = 1'b1;
            else if (clr)   malarm = 1'b0;
        end
    end

    always @(negedge CLK) begin
        logic [4:0] hw;
        hw = (mq.size() > 0) ? mq[0].word : 5'd0;
        chk("m_in_ready", in_ready, mq.size() < 2);
        chk("m_out_valid", out_valid, mq.size() > 0);
        chk("m_out_sum", out_sum, hw[3:0]);
        chk("m_out_cout", out_cout, hw[4]);
        chk("m_out_fault", out_fault, (mq.size() > 0) ? mq[0].f : 1'b0);
        chk("m_out_uncorr", out_uncorr, (mq.size() > 0) ? mq[0].u : 1'b0);
        chk("m_cnt8", cnt8, mcnt8);
        chk("m_cnt2", cnt2, mcnt2);
        chk("m_sum_b", out_sum_b, hw[3:0]);
`ifdef FT_STICKY_ALARM_EN
        chk("m_alarm", alarm, malarm);
`endif
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic setw(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
        {c0, s0} = a;
        {c1, s1} = b;
        {c2, s2} = c;
    endtask

    task automatic rand_word();
        logic [4:0] base, w0, w1, w2;
        int k;
        base = 5'($urandom);
        w0 = base; w1 = base; w2 = base;
        k = $urandom_range(0, 3);
        if (k >= 1) w1 = w1 ^ 5'($urandom_range(1, 31));
        if (k >= 2) w2 = w2 ^ 5'($urandom_range(1, 31));
        if (k == 3) w0 = w0 ^ 5'($urandom_range(1, 31));
        setw(w0, w1, w2);
    endtask

    initial begin
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_cnt", cnt8, 0);
        RST = 1'b0;

        // T1: clean word
        out_ready = 1'b1;
        setw(5'h05, 5'h05, 5'h05);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t1_valid", out_valid, 1);
        chk("t1_sum", out_sum, 5);
        chk("t1_cout", out_cout, 0);
        chk("t1_fault", out_fault, 0);
        chk("t1_uncorr", out_uncorr, 0);
        chk("t1_cnt", cnt8, 0);
        step();

        // T2: one copy disagrees in the carry and a sum bit
        setw(5'h09, 5'h09, 5'h11);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t2_sum", out_sum, 9);
        chk("t2_cout", out_cout, 0);
        chk("t2_fault", out_fault, 1);
        chk("t2_uncorr", out_uncorr, 0);
        chk("t2_cnt", cnt8, 1);
        step();

        // T3: all three copies disagree with the vote
        setw(5'h03, 5'h05, 5'h06);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t3_sum", out_sum, 7);
        chk("t3_fault", out_fault, 1);
        chk("t3_uncorr", out_uncorr, 1);
        chk("t3_cnt", cnt8, 2);
`ifdef FT_STICKY_ALARM_EN
        chk("t3_alarm", alarm, 1);
        step();
        chk("t3_alarm_hold", alarm, 1);
`endif
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("t3_cnt_clr", cnt8, 0);
`ifdef FT_STICKY_ALARM_EN
        chk("t3_alarm_clr", alarm, 0);
        clr = 1'b1;
        setw(5'h03, 5'h05, 5'h06);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t3_alarm_setwins", alarm, 1);
        chk("t3_cnt_clrwins", cnt8, 0);
        step();
        clr = 1'b0;
`endif

        // T4: backpressure fills the queue
        out_ready = 1'b0;
        step();
        setw(5'h01, 5'h01, 5'h01);
        in_valid = 1'b1;
        step();
        setw(5'h02, 5'h02, 5'h02);
        step();
        chk("t4_full_rdy", in_ready, 0);
        chk("t4_head", out_sum, 1);
        setw(5'h03, 5'h03, 5'h03);
        step();
        step();
        chk("t4_hold_sum", out_sum, 1);
        chk("t4_hold_rdy", in_ready, 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("t4_pop1_sum", out_sum, 2);
        chk("t4_pop1_rdy", in_ready, 1);
        step();
        chk("t4_pop2_valid", out_valid, 0);
        chk("t4_pop2_sum", out_sum, 0);

        // T5: counter saturation on the 2-bit instance
        setw(5'h01, 5'h01, 5'h02);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_cnt2", cnt2, (i < 3) ? i + 1 : 3);
            chk("t5_cnt8", cnt8, i + 1);
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        in_valid = 1'b0;
        chk("t5_clr_cnt2", cnt2, 0);
        chk("t5_clr_cnt8", cnt8, 0);
        step();

        // T6: reset while full
        out_ready = 1'b0;
        setw(5'h0A, 5'h0A, 5'h0B);
        in_valid = 1'b1;
        step();
        setw(5'h0C, 5'h0C, 5'h0C);
        step();
        in_valid = 1'b0;
        chk("t6_full", in_ready, 0);
        chk("t6_cnt", cnt8, 1);
        #2 RST = 1'b1;
        #1;
        chk("t6_rst_rdy", in_ready, 1);
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_sum", out_sum, 0);
        chk("t6_rst_fault", out_fault, 0);
        chk("t6_rst_cnt", cnt8, 0);
        #3 RST = 1'b0;
        step();
        out_ready = 1'b1;
        setw(5'h09, 5'h09, 5'h09);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t6_first_valid", out_valid, 1);
        chk("t6_first_sum", out_sum, 9);
        step();

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if (!(in_valid && !in_ready)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                rand_word();
            end
            out_ready = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 49) == 0);
            step();
        end

        // 8-bit counter saturation
        clr = 1'b1;
        in_valid = 1'b0;
        step();
        clr = 1'b0;
        out_ready = 1'b1;
        setw(5'h04, 5'h04, 5'h14);
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) step();
        in_valid = 1'b0;
        chk("sat_cnt8", cnt8, 255);
        chk("sat_cnt2", cnt2, 3);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
